// File: rtl/dm_access_ctrl.sv
// JOF32 memory-stage data-memory access controller: req/gnt/rvalid handshake,
// byte-lane load alignment, read-modify-write byte stores, per-phase timeout.
module dm_access_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ld_byte,
  input  logic              st_byte,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       lw,
  output logic              ld_valid,
  output logic              bus_err,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [31:0]       dm_rdata
);

  localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             is_load;
  logic             byte_ld;
  logic [1:0]       lane;
  logic [7:0]       wbyte;

  logic             op, bad, timeout, busy;
  logic             err_set, ld_set;
  logic [7:0]       lane_byte;
  logic [31:0]      merged;

  assign op   = mem_read | mem_write;
  assign bad  = (mem_read & mem_write)
              | (mem_read  & ~ld_byte & (addr[1:0] != 2'b00))
              | (mem_write & ~st_byte & (addr[1:0] != 2'b00));
  assign busy = (state == RD) | (state == RWAIT) | (state == WR);
  // cnt is 0 on the first cycle in a phase, so MAX_WAIT-1 marks the MAX_WAIT-th cycle
  assign timeout = (cnt == CNT_W'(MAX_WAIT - 1));

  // reset gating keeps the pipeline free while the controller is held in reset
  assign stall = rst_n & (((state == IDLE) & op) | busy);

  always_comb begin
    lane_byte = dm_rdata[{lane, 3'b000} +: 8];
    merged    = dm_rdata;
    merged[{lane, 3'b000} +: 8] = wbyte;
  end

  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    ld_set     = 1'b0;
    unique case (state)
      IDLE: begin
        if (op) begin
          if (bad) begin
            state_next = DONE;
            err_set    = 1'b1;
          end else if (mem_read || st_byte) begin
            state_next = RD;
          end else begin
            state_next = WR;
          end
        end
      end
      RD: begin
        if (dm_gnt) begin
          state_next = RWAIT;
        end else if (timeout) begin
          state_next = DONE;
          err_set    = 1'b1;
        end
      end
      RWAIT: begin
        if (dm_rvalid) begin
          state_next = is_load ? DONE : WR;
          ld_set     = is_load;
        end else if (timeout) begin
          state_next = DONE;
          err_set    = 1'b1;
        end
      end
      WR: begin
        if (dm_gnt) begin
          state_next = DONE;
        end else if (timeout) begin
          state_next = DONE;
          err_set    = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      lw       <= '0;
      ld_valid <= 1'b0;
      bus_err  <= 1'b0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      is_load  <= 1'b0;
      byte_ld  <= 1'b0;
      lane     <= '0;
      wbyte    <= '0;
    end else begin
      ld_valid <= ld_set;
      bus_err  <= err_set;
      dm_req   <= (state_next == RD) || (state_next == WR);
      dm_we    <= (state_next == WR);

      if (state_next != state)
        cnt <= '0;
      else if (busy)
        cnt <= cnt + 1'b1;

      if ((state == IDLE) && op && !bad) begin
        dm_addr <= {addr[ADDR_W-1:2], 2'b00};
        is_load <= mem_read;
        byte_ld <= ld_byte;
        lane    <= addr[1:0];
        wbyte   <= wdata[7:0];
        if (!mem_read && !st_byte)
          dm_wdata <= wdata;
      end

      if ((state == RWAIT) && dm_rvalid) begin
        if (is_load)
          lw <= byte_ld ? {24'h0, lane_byte} : dm_rdata;
        else
          dm_wdata <= merged;
      end
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: memory responder with programmable
// gnt/rvalid latency, expected loads/writes/errors queued at issue time.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, ld_byte, st_byte;
  logic [31:0] addr, wdata;
  logic        stall, ld_valid, bus_err, dm_req, dm_we;
  logic [31:0] lw, dm_addr, dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;

  dm_access_ctrl #(.ADDR_W(32), .MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .ld_byte(ld_byte), .st_byte(st_byte),
    .addr(addr), .wdata(wdata),
    .stall(stall), .lw(lw), .ld_valid(ld_valid), .bus_err(bus_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;  // 0 load result, 1 memory write, 2 bus error
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  int          nchecks = 0;
  int          nerrors = 0;
  int          gnt_lat = 0;
  int          rv_lat  = 0;
  int          req_cnt = 0;
  int          rv_cnt  = 0;
  bit          rv_pend = 0;
  bit          manual  = 0;
  logic [31:0] rv_addr;
  logic [31:0] last_lw = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    logic [31:0] wa;
    wa = a & ~32'h3;
    return ref_mem.exists(wa) ? ref_mem[wa] : 32'h0;
  endfunction

  // monitor + memory responder, all on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (ld_valid) begin
      if (sb.size() == 0) check("ld_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("ld_kind", 32'd0, e.kind);
        check("lw", lw, e.d);
      end
    end
    if (bus_err) begin
      if (sb.size() == 0) check("err_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("err_kind", 32'd2, e.kind);
      end
    end
    if (manual) begin
      req_cnt = 0;
      rv_pend = 0;
    end else begin
      dm_gnt    = 1'b0;
      dm_rvalid = 1'b0;
      if (rst_n) begin
        if (rv_pend) begin
          if (rv_cnt == rv_lat) begin
            dm_rvalid = 1'b1;
            dm_rdata  = mem.exists(rv_addr) ? mem[rv_addr] : 32'h0;
            rv_pend   = 0;
          end else rv_cnt++;
        end
        if (dm_req) begin
          if (req_cnt == gnt_lat) begin
            dm_gnt  = 1'b1;
            req_cnt = 0;
            if (dm_we) begin
              if (sb.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
              else begin
                e = sb.pop_front();
                check("wr_kind", 32'd1, e.kind);
                check("wr_addr", dm_addr, e.a);
                check("wr_data", dm_wdata, e.d);
              end
              mem[dm_addr] = dm_wdata;
            end else begin
              rv_pend = 1;
              rv_cnt  = 0;
              rv_addr = dm_addr;
            end
          end else req_cnt++;
        end else req_cnt = 0;
      end
    end
  end

  task automatic set_mem(input logic [31:0] a, input logic [31:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  task automatic do_op(input logic r, input logic w, input logic lb, input logic sbt,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int exp_stall, input int exp_req);
    int n, nreq;
    @(negedge clk); #1;
    mem_read = r; mem_write = w; ld_byte = lb; st_byte = sbt; addr = a; wdata = wd;
    #1;
    n = 0; nreq = 0;
    while (stall && n < 60) begin
      n++;
      if (dm_req) nreq++;
      @(negedge clk); #2;
    end
    mem_read = 0; mem_write = 0; ld_byte = 0; st_byte = 0;
    check("stall_cycles", n, exp_stall);
    check("req_cycles", nreq, exp_req);
  endtask

  task automatic load_op(input logic [31:0] a, input logic b, input int es, input int er);
    logic [31:0] w, e;
    w = rd_ref(a);
    e = b ? ((w >> (8 * a[1:0])) & 32'hFF) : w;
    sb.push_back(exp_t'{kind: 0, a: a & ~32'h3, d: e});
    last_lw = e;
    do_op(1'b1, 1'b0, b, 1'b0, a, 32'h0, es, er);
  endtask

  task automatic store_op(input logic [31:0] a, input logic [31:0] wd, input logic b,
                          input int es, input int er);
    logic [31:0] w, nw, wa;
    wa = a & ~32'h3;
    w  = rd_ref(a);
    nw = b ? ((w & ~(32'hFF << (8 * a[1:0]))) | ((wd & 32'hFF) << (8 * a[1:0]))) : wd;
    ref_mem[wa] = nw;
    sb.push_back(exp_t'{kind: 1, a: wa, d: nw});
    do_op(1'b0, 1'b1, 1'b0, b, a, wd, es, er);
  endtask

  task automatic err_op(input logic r, input logic w, input logic lb, input logic sbt,
                        input logic [31:0] a);
    sb.push_back(exp_t'{kind: 2, a: 32'h0, d: 32'h0});
    do_op(r, w, lb, sbt, a, 32'h5A5A5A5A, 1, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    mem_read = 0; mem_write = 0; ld_byte = 0; st_byte = 0;
    addr = '0; wdata = '0;
    dm_gnt = 0; dm_rvalid = 0; dm_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_lw", lw, 0);
    check("rst_ld_valid", ld_valid, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_dm_req", dm_req, 0);
    check("rst_dm_we", dm_we, 0);
    check("rst_dm_addr", dm_addr, 0);
    check("rst_dm_wdata", dm_wdata, 0);
    rst_n = 1'b1;

    // minimum-latency traffic
    set_mem(32'h100, 32'hDEADBEEF);
    load_op(32'h100, 1'b0, 3, 1);
    set_mem(32'h100, 32'h11223344);
    load_op(32'h103, 1'b1, 3, 1);
    load_op(32'h101, 1'b1, 3, 1);
    load_op(32'h100, 1'b1, 3, 1);
    store_op(32'h102, 32'h000000AB, 1'b1, 4, 2);
    load_op(32'h100, 1'b0, 3, 1);
    store_op(32'h300, 32'h12345678, 1'b0, 2, 1);
    load_op(32'h300, 1'b0, 3, 1);
    store_op(32'h301, 32'hFFFFFFCD, 1'b1, 4, 2);
    load_op(32'h300, 1'b0, 3, 1);

    // slow memory
    gnt_lat = 2; rv_lat = 3;
    load_op(32'h102, 1'b1, 8, 3);
    store_op(32'h203, 32'h00000077, 1'b1, 11, 6);
    load_op(32'h200, 1'b0, 8, 3);
    gnt_lat = 0; rv_lat = 0;

    // illegal accesses: no memory traffic, single stall cycle
    err_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h102);
    err_op(1'b1, 1'b1, 1'b0, 1'b0, 32'h100);
    err_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h301);
    load_op(32'h100, 1'b0, 3, 1);

    // grant never comes: timeout after MAX_WAIT cycles in RD
    gnt_lat = 1000;
    sb.push_back(exp_t'{kind: 2, a: 32'h0, d: 32'h0});
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 32'h0, 16, 15);
    check("timeout_lw_hold", lw, last_lw);
    gnt_lat = 0;

    // reset while waiting for read data
    @(negedge clk); #1;
    manual = 1; dm_gnt = 0; dm_rvalid = 0;
    mem_read = 1; ld_byte = 0; addr = 32'h100;
    @(negedge clk); #1;
    check("rd_req", dm_req, 1);
    dm_gnt = 1;
    @(negedge clk); #1;
    dm_gnt = 0;
    check("rwait_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall", stall, 0);
    check("rst_mid_req", dm_req, 0);
    mem_read = 0;
    @(negedge clk); #1;
    dm_rvalid = 1; dm_rdata = 32'hCAFEF00D;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    dm_rvalid = 0;
    check("late_rv_ld_valid", ld_valid, 0);
    check("late_rv_lw", lw, 0);
    check("post_rst_stall", stall, 0);
    check("post_rst_req", dm_req, 0);
    manual = 0;
    load_op(32'h300, 1'b0, 3, 1);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
